instr_encoder: RTL and testbench
================================

# instr_encoder

Streaming RV32 instruction encoder, the inverse of the decode-stage field splitter. It accepts decoded instruction fields over a valid/ready handshake and packs them into a 32-bit instruction word for R, I, load, S and B formats. Each packed word is tagged with a sequential word address and buffered in a 2-entry output FIFO. It sits between the test/program generator and the instruction-memory write port.

## Interface
- `ADDR_W`, 10: width of the word-address counter.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `restart` input 1: synchronous pulse; flushes the FIFO and zeroes the address counter.
- `in_valid` input 1: field bundle valid.
- `in_ready` output 1: bundle accepted on an edge where `in_valid && in_ready`.
- `opcode` input 7: instruction opcode.
- `rd` input 5: destination register.
- `funct3` input 3: funct3 field.
- `rs1` input 5: source register 1.
- `rs2` input 5: source register 2.
- `funct7` input 7: funct7 field.
- `imm` input 13: immediate; the format decides which bits are used.
- `out_valid` output 1: FIFO head valid.
- `out_ready` input 1: head consumed on an edge where `out_valid && out_ready`.
- `out_instr` output 32: encoded word at the FIFO head.
- `out_addr` output ADDR_W: word address of the head.
- `err` output 1: one-cycle pulse when an unsupported opcode is accepted.
- `err_count` output 8: saturating count of unsupported opcodes.

## Operation
**Encoding**, with fields concatenated MSB first:
- R-type, opcode 0110011: {funct7, rs2, rs1, funct3, rd, opcode}.
- I-type (0010011) and load (0000011): {imm[11:0], rs1, funct3, rd, opcode}.
- S-type, opcode 0100011: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
- B-type, opcode 1100011: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- Unused inputs are ignored. `imm[0]` is ignored for B-type.

**Unsupported opcodes**
- Any other opcode is still accepted (consumed) but produces no FIFO entry.
- `err` pulses and `err_count` increments, saturating at 255.
- The address counter does not advance.

**FIFO and address**
- FIFO is 2 entries deep. Each entry holds {instr, addr}.
- `in_ready = !rst && !restart && (count < 2)`. This is combinational from registered state only; it never depends on `out_ready`.
- A supported accept pushes {encoded word, addr_cnt}, then `addr_cnt` advances by 1.
- `addr_cnt` wraps from 2^ADDR_W−1 to 0.
- Push and pop on the same edge leave the count unchanged and keep entry order intact.

**Restart**
- `restart` clears the FIFO and sets `addr_cnt` to 0.
- No accept occurs in the restart cycle.
- `err_count` is preserved across restart.

**Reset**
- Async assert clears everything: `out_valid`=0, `out_instr`=0, `out_addr`=0, `err`=0, `err_count`=0, count=0, `addr_cnt`=0.
- `in_ready`=0 while `rst` is high.
- Reset mid-stream discards all buffered entries.

## Timing
- Latency: a bundle accepted at edge N is visible on `out_*` after edge N if the FIFO was empty. Otherwise it appears behind the older entry.
- Throughput: 1 word/cycle when `out_ready` is held high.
- `out_instr` and `out_addr` are stable while `out_valid && !out_ready`.
- `err` is registered and asserts the cycle after the accepting edge, for exactly one cycle.
- Full FIFO: `in_ready` drops after the second push and returns the cycle after a pop.

## Test plan
- **R-type:** opcode=0110011, rd=3, rs1=1, rs2=2, funct3=0, funct7=0, `out_ready`=1 → `out_instr`=0x002081B3, `out_addr`=0, one cycle after accept.
- **I-type, load, S-type:** send back-to-back with `out_ready`=1:
  - addi x1,x0,5 → 0x00500093 at addr 0.
  - lw x5,8(x2) → 0x00812283 at addr 1.
  - sw x5,12(x2) → 0x00512623 at addr 2.
- **B-type with negative immediate:** beq x1,x2,imm=−8 (13'h1FF8) → 0xFE208CE3.
- **Backpressure:**
  - `out_ready`=0 with 3 valid bundles → 2 accepted; `in_ready`=0 from the cycle after the second accept.
  - Raise `out_ready` → words drain in order, addrs 0 then 1; the third bundle is then accepted with addr 2.
- **Unsupported opcode:** opcode=1111111 → accepted, no `out_valid`, `err` pulses once, `err_count`=1, next valid word still gets the next sequential addr.
  - Drive 300 such bundles → `err_count` saturates at 255.
- **Wrap, restart and reset:**
  - ADDR_W=2: 5 supported words → addrs 0,1,2,3,0.
  - `restart` with 2 words buffered → `out_valid`=0 next cycle, next word at addr 0, `err_count` kept.
  - Async `rst` mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/instr_encoder.sv
// Streaming RV32 instruction encoder: packs decoded fields (R/I/load/S/B) into a
// 32-bit word, tags it with a sequential word address and buffers it in a 2-entry FIFO.
module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [6:0]        funct7,
    input  logic [12:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [7:0]        err_count
);
    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // in_ready depends only on registered state (plus rst/restart), never on out_ready.

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;

    logic [31:0]       word;
    logic              supported;
    logic              accept;
    logic              push;
    logic              pop;
    logic [1:0]        count;
    logic [ADDR_W-1:0] addr_cnt;
    logic [31:0]       instr_q [2];
    logic [ADDR_W-1:0] addr_q  [2];

    always_comb begin
        word      = '0;
        supported = 1'b1;
        case (opcode)
            OP_R:          word = {funct7, rs2, rs1, funct3, rd, opcode};
            OP_I, OP_LOAD: word = {imm[11:0], rs1, funct3, rd, opcode};
            OP_S:          word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            OP_B:          word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            default:       supported = 1'b0;
        endcase
    end

    assign in_ready  = !rst && !restart && (count < 2'd2);
    assign accept    = in_valid && in_ready;
    assign push      = accept && supported;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_instr = instr_q[0];
    assign out_addr  = addr_q[0];

    // Slot 0 is always the head; slot 1 only holds the younger entry when full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= 2'd0;
            addr_cnt   <= '0;
            instr_q[0] <= '0;
            instr_q[1] <= '0;
            addr_q[0]  <= '0;
            addr_q[1]  <= '0;
            err        <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            err <= accept && !supported;
            if (accept && !supported && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (restart) begin
                count    <= 2'd0;
                addr_cnt <= '0;
            end else begin
                if (push) begin
                    addr_cnt <= addr_cnt + ADDR_W'(1);
                end
                case (count)
                    2'd0: begin
                        if (push) begin
                            instr_q[0] <= word;
                            addr_q[0]  <= addr_cnt;
                            count      <= 2'd1;
                        end
                    end
                    2'd1: begin
                        if (push && pop) begin
                            instr_q[0] <= word;
                            addr_q[0]  <= addr_cnt;
                        end else if (push) begin
                            instr_q[1] <= word;
                            addr_q[1]  <= addr_cnt;
                            count      <= 2'd2;
                        end else if (pop) begin
                            count      <= 2'd0;
                        end
                    end
                    2'd2: begin
                        // Full: in_ready is low, so only a pop can happen here.
                        if (pop) begin
                            instr_q[0] <= instr_q[1];
                            addr_q[0]  <= addr_q[1];
                            count      <= 2'd1;
                        end
                    end
                    default: count <= 2'd0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed cases from the encoding table plus a randomized
// stream, all checked against a queue-based reference model.
module tb_instr_encoder;
    localparam int AW = 2;
    localparam int W  = 32 + AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          restart = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [6:0]    opcode = '0;
    logic [4:0]    rd = '0;
    logic [2:0]    funct3 = '0;
    logic [4:0]    rs1 = '0;
    logic [4:0]    rs2 = '0;
    logic [6:0]    funct7 = '0;
    logic [12:0]   imm = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic          err;
    logic [7:0]    err_count;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] exp_q[$];
    int           m_addr = 0;
    logic         m_err = 1'b0;
    int           m_errcnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_supported(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
    endfunction

    // Field placement from the instruction-format table, by bit position arithmetic.
    function automatic logic [31:0] ref_encode(input logic [6:0] op, input logic [4:0] d,
                                               input logic [2:0] f3, input logic [4:0] s1,
                                               input logic [4:0] s2, input logic [6:0] f7,
                                               input logic [12:0] im);
        int unsigned o = op, dd = d, f = f3, a = s1, b = s2, g = f7, i = im;
        int unsigned common = o + f * 4096 + a * 32768;
        case (op)
            7'h33:        return common + dd * 128 + b * (1 << 20) + g * (1 << 25);
            7'h13, 7'h03: return common + dd * 128 + (i % 4096) * (1 << 20);
            7'h23:        return common + (i % 32) * 128 + b * (1 << 20) + ((i / 32) % 128) * (1 << 25);
            7'h63:        return common + ((i / 2048) % 2) * 128 + ((i / 2) % 16) * 256
                                 + b * (1 << 20) + ((i / 32) % 64) * (1 << 25)
                                 + ((i / 4096) % 2) * 32'h8000_0000;
            default:      return 32'd0;
        endcase
    endfunction

    // One clock cycle: apply inputs at the falling edge, check, advance model, step.
    task automatic cycle(input logic v, input logic [6:0] op, input logic [4:0] d,
                         input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [6:0] f7, input logic [12:0] im,
                         input logic ordy, input logic rs);
        bit m_ready;
        bit acc;
        in_valid = v; opcode = op; rd = d; funct3 = f3; rs1 = s1; rs2 = s2;
        funct7 = f7; imm = im; out_ready = ordy; restart = rs;
        #1;
        m_ready = !rs && (exp_q.size() < 2);
        check("in_ready", 32'(in_ready), 32'(m_ready));
        check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            check("out_instr", out_instr, exp_q[0][W-1:AW]);
            check("out_addr", 32'(out_addr), 32'(exp_q[0][AW-1:0]));
        end
        check("err", 32'(err), 32'(m_err));
        check("err_count", 32'(err_count), 32'(m_errcnt));
        acc = v && m_ready;
        if (rs) begin
            exp_q.delete();
            m_addr = 0;
        end else begin
            if (ordy && exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc && is_supported(op)) begin
                exp_q.push_back({ref_encode(op, d, f3, s1, s2, f7, im), AW'(m_addr)});
                m_addr = (m_addr + 1) % (1 << AW);
            end
        end
        m_err = acc && !is_supported(op);
        if (m_err && m_errcnt < 255) m_errcnt++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 7'h0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 13'd0, ordy, 1'b0);
    endtask

    task automatic do_restart();
        cycle(1'b1, 7'h33, 5'd9, 3'd0, 5'd9, 5'd9, 7'd0, 13'd0, 1'b0, 1'b1);
    endtask

    task automatic send_r(input logic [4:0] d, input logic ordy);
        cycle(1'b1, 7'h33, d, 3'd1, 5'd4, 5'd6, 7'h20, 13'd0, ordy, 1'b0);
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_addr = 0;
        m_err = 1'b0;
        m_errcnt = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_instr"}, out_instr, 32'd0);
        check({tag, "_out_addr"}, 32'(out_addr), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    int exp_wrap[5] = '{0, 1, 2, 3, 0};
    logic [6:0] ops[5] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63};

    initial begin
        // Power-on reset
        #1;
        check_zero_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();

        // R-type: add x3,x1,x2
        cycle(1'b1, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 13'd0, 1'b1, 1'b0);
        check("rtype_valid", 32'(out_valid), 32'd1);
        check("rtype_instr", out_instr, 32'h002081B3);
        check("rtype_addr", 32'(out_addr), 32'd0);
        idle(1'b1);

        // addi / lw / sw / beq back to back after a restart
        do_restart();
        cycle(1'b1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd31, 7'h7F, 13'd5, 1'b1, 1'b0);
        check("addi_instr", out_instr, 32'h00500093);
        check("addi_addr", 32'(out_addr), 32'd0);
        cycle(1'b1, 7'h03, 5'd5, 3'd2, 5'd2, 5'd0, 7'd0, 13'd8, 1'b1, 1'b0);
        check("lw_instr", out_instr, 32'h00812283);
        check("lw_addr", 32'(out_addr), 32'd1);
        cycle(1'b1, 7'h23, 5'd0, 3'd2, 5'd2, 5'd5, 7'd0, 13'd12, 1'b1, 1'b0);
        check("sw_instr", out_instr, 32'h00512623);
        check("sw_addr", 32'(out_addr), 32'd2);
        cycle(1'b1, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 13'h1FF8, 1'b1, 1'b0);
        check("beq_instr", out_instr, 32'hFE208CE3);
        check("beq_addr", 32'(out_addr), 32'd3);
        idle(1'b1);

        // Backpressure: two accepted, third held until a slot frees
        do_restart();
        send_r(5'd10, 1'b0);
        send_r(5'd11, 1'b0);
        check("bp_full_ready", 32'(in_ready), 32'd0);
        send_r(5'd12, 1'b0);
        send_r(5'd12, 1'b1);
        check("bp_drain1_addr", 32'(out_addr), 32'd1);
        send_r(5'd12, 1'b1);
        check("bp_third_addr", 32'(out_addr), 32'd2);
        idle(1'b1);

        // Unsupported opcode
        cycle(1'b1, 7'h7F, 5'd1, 3'd1, 5'd1, 5'd1, 7'd1, 13'd1, 1'b1, 1'b0);
        check("unsup_err", 32'(err), 32'd1);
        check("unsup_err_count", 32'(err_count), 32'd1);
        check("unsup_no_valid", 32'(out_valid), 32'd0);
        idle(1'b1);
        check("unsup_err_pulse", 32'(err), 32'd0);
        send_r(5'd13, 1'b1);
        check("unsup_next_addr", 32'(out_addr), 32'd3);
        idle(1'b1);

        // Saturation
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 7'h7F, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 13'd0, 1'b1, 1'b0);
        end
        idle(1'b1);
        check("err_saturate", 32'(err_count), 32'd255);

        // Restart with two words buffered
        send_r(5'd14, 1'b0);
        send_r(5'd15, 1'b0);
        do_restart();
        check("restart_flush", 32'(out_valid), 32'd0);
        check("restart_errcnt", 32'(err_count), 32'd255);
        send_r(5'd16, 1'b1);
        check("restart_addr", 32'(out_addr), 32'd0);
        idle(1'b1);

        // Address wrap
        do_restart();
        for (int i = 0; i < 5; i++) begin
            send_r(5'(i), 1'b1);
            check("wrap_addr", 32'(out_addr), 32'(exp_wrap[i]));
        end
        idle(1'b1);

        // Async reset mid-stream
        send_r(5'd20, 1'b0);
        send_r(5'd21, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_zero_outputs("async_rst");
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(1'b1);

        // Randomized stream
        for (int i = 0; i < 2000; i++) begin
            int sel;
            logic [6:0] op;
            sel = $urandom_range(0, 5);
            op = (sel < 5) ? ops[sel] : 7'($urandom);
            cycle($urandom_range(0, 3) != 0, op, 5'($urandom), 3'($urandom), 5'($urandom),
                  5'($urandom), 7'($urandom), 13'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        end
        idle(1'b1);
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
